uart_rx_frame: RTL and testbench

Parametrised UART receiver, successor to the fixed 8N1 byte receiver. Frame format (data width, parity, stop bits), baud rate and oversampling are compile-time parameters. Adds 3-sample majority voting, false-start rejection, and parity/framing/break detection. Sits directly behind the board RX pin and feeds command parsers and the activity LED.

---
 rtl/uart_rx_frame.sv | 175 +++++++++++++++++
 tb/tb_uart_rx_frame.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: 2-FF synchroniser, 3-sample majority vote per bit,
// false-start rejection, and parity/framing/break detection on each completed frame.
module uart_rx_frame #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 led
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W    = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  SMP_A     = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  SMP_B     = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0]  SMP_C     = OS_W'(OVERSAMPLE / 2 + 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_HIGH} state_t;

  state_t                 state;
  logic                   sync_p0, sync_p1, sync_p2;
  logic                   fall, tick, voted;
  logic [DIV_W-1:0]       div_cnt;
  logic [OS_W-1:0]        tick_cnt;
  logic [3:0]             bit_cnt;
  logic                   v_a, v_b;
  logic [DATA_BITS-1:0]   shift;
  logic                   par_bad, stop_low, any_one;
  logic                   stop_low_n, any_n;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic exp_parity(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~^d : ^d;
  endfunction

  // Synchroniser (p0, p1) and edge register (p2); idle line level is 1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      sync_p2 <= 1'b1;
    end else begin
      sync_p0 <= uart_rx;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign fall       = sync_p2 & ~sync_p1;
  assign tick       = (div_cnt == DIV_LAST);
  assign voted      = maj3(v_a, v_b, sync_p1);
  assign stop_low_n = stop_low | ~voted;
  assign any_n      = any_one | voted;

  // Frame FSM: bit cells are timed from the detected start edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      div_cnt    <= '0;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      v_a        <= 1'b1;
      v_b        <= 1'b1;
      shift      <= '0;
      par_bad    <= 1'b0;
      stop_low   <= 1'b0;
      any_one    <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
      led        <= 1'b0;
    end else begin
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
      case (state)
        IDLE: begin
          div_cnt  <= '0;
          tick_cnt <= '0;
          if (fall) begin
            state    <= START;
            bit_cnt  <= '0;
            par_bad  <= 1'b0;
            stop_low <= 1'b0;
            any_one  <= 1'b0;
          end
        end
        WAIT_HIGH: begin
          // Any low sample restarts the one-bit-time high qualification
          if (!sync_p1) begin
            div_cnt  <= '0;
            tick_cnt <= '0;
          end else if (tick) begin
            div_cnt  <= '0;
            tick_cnt <= (tick_cnt == OS_LAST) ? '0 : tick_cnt + 1'b1;
            if (tick_cnt == OS_LAST) state <= IDLE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: begin
          if (tick) begin
            div_cnt  <= '0;
            tick_cnt <= (tick_cnt == OS_LAST) ? '0 : tick_cnt + 1'b1;
            if (tick_cnt == SMP_A) v_a <= sync_p1;
            if (tick_cnt == SMP_B) v_b <= sync_p1;
            if (tick_cnt == SMP_C) begin
              case (state)
                START: state <= voted ? IDLE : DATA;
                DATA: begin
                  shift   <= {voted, shift[DATA_BITS-1:1]};
                  any_one <= any_n;
                  if (bit_cnt == DATA_LAST) begin
                    bit_cnt <= '0;
                    state   <= (PARITY != 0) ? PAR : STOP;
                  end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                  end
                end
                PAR: begin
                  par_bad <= (voted != exp_parity(shift));
                  any_one <= any_n;
                  state   <= STOP;
                end
                default: begin
                  if (bit_cnt == STOP_LAST) begin
                    rx_data    <= shift;
                    rx_valid   <= 1'b1;
                    parity_err <= par_bad;
                    frame_err  <= stop_low_n;
                    break_det  <= ~any_n;
                    if (!par_bad && !stop_low_n) led <= ~led;
                    div_cnt    <= '0;
                    tick_cnt   <= '0;
                    state      <= sync_p1 ? IDLE : WAIT_HIGH;
                  end else begin
                    stop_low <= stop_low_n;
                    any_one  <= any_n;
                    bit_cnt  <= bit_cnt + 4'd1;
                  end
                end
              endcase
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: three receivers (8N1, 8E1, 7O2) driven by directed frames,
// checked every cycle against a frame-level model plus literal spot checks.
module tb_uart_rx_frame;

  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD     = 115200;
  localparam int OS       = 16;
  localparam int BIT      = (CLK_FREQ / (BAUD * OS)) * OS;

  logic       clk = 1'b0;
  logic [2:0] rst_n;
  logic [2:0] line;
  logic [7:0] d_a, d_b;
  logic [6:0] d_c;
  logic [2:0] v, pe, fe, bd, led;

  always #10 clk = ~clk;

  uart_rx_frame #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .OVERSAMPLE(OS)) dut_a (
    .clk(clk), .reset_n(rst_n[0]), .uart_rx(line[0]), .rx_data(d_a), .rx_valid(v[0]),
    .parity_err(pe[0]), .frame_err(fe[0]), .break_det(bd[0]), .led(led[0]));

  uart_rx_frame #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(1), .OVERSAMPLE(OS)) dut_b (
    .clk(clk), .reset_n(rst_n[1]), .uart_rx(line[1]), .rx_data(d_b), .rx_valid(v[1]),
    .parity_err(pe[1]), .frame_err(fe[1]), .break_det(bd[1]), .led(led[1]));

  uart_rx_frame #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(7), .PARITY(1),
                  .STOP_BITS(2), .OVERSAMPLE(OS)) dut_c (
    .clk(clk), .reset_n(rst_n[2]), .uart_rx(line[2]), .rx_data(d_c), .rx_valid(v[2]),
    .parity_err(pe[2]), .frame_err(fe[2]), .break_det(bd[2]), .led(led[2]));

  typedef struct {
    int         id;
    logic [8:0] data;
    logic       pe;
    logic       fe;
    logic       bd;
  } exp_t;

  exp_t       q[$];
  logic [8:0] exp_data [3];
  logic       exp_led  [3];
  int         vcnt     [3];
  logic       last_pe  [3];
  logic       last_fe  [3];
  logic       last_bd  [3];
  int         checks   = 0;
  int         failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Parity bit a correct transmitter would send: odd mode makes total ones odd
  function automatic logic par_bit(input logic [8:0] data, input int dbits, input int pmode);
    int ones;
    ones = 0;
    for (int i = 0; i < dbits; i++) ones += int'(data[i]);
    return (pmode == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  task automatic push_exp(input int id, input logic [8:0] data, input logic p, input logic f,
                          input logic b);
    exp_t e;
    e.id = id; e.data = data; e.pe = p; e.fe = f; e.bd = b;
    q.push_back(e);
  endtask

  task automatic bit_out(input int id, input logic lvl);
    line[id] = lvl;
    repeat (BIT) @(posedge clk);
  endtask

  // pforce < 0 sends the correct parity; stops[i] is the level of stop bit i
  task automatic send_frame(input int id, input int dbits, input int pmode, input int nstop,
                            input logic [8:0] data, input int pforce, input logic [1:0] stops);
    logic       pok, pb, f, zero;
    logic [8:0] dm;
    pok  = par_bit(data, dbits, pmode);
    pb   = (pforce < 0) ? pok : pforce[0];
    dm   = data & 9'((1 << dbits) - 1);
    f    = 1'b0;
    zero = (dm == 9'd0) && (pmode == 0 || !pb);
    for (int i = 0; i < nstop; i++) begin
      if (!stops[i]) f = 1'b1;
      else zero = 1'b0;
    end
    push_exp(id, dm, (pmode != 0) && (pb != pok), f, zero);
    bit_out(id, 1'b0);
    for (int i = 0; i < dbits; i++) bit_out(id, data[i]);
    if (pmode != 0) bit_out(id, pb);
    for (int i = 0; i < nstop; i++) bit_out(id, stops[i]);
  endtask

  task automatic check_dut(input int id, input logic [8:0] d, input logic vv, input logic pp,
                           input logic ff, input logic bb, input logic ll);
    exp_t e;
    if (vv) begin
      vcnt[id]++;
      last_pe[id] = pp; last_fe[id] = ff; last_bd[id] = bb;
      if (q.size() == 0 || q[0].id != id) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid dut%0d actual=1 required=0", id);
      end else begin
        e = q.pop_front();
        chk($sformatf("parity_err_dut%0d", id), 32'(pp), 32'(e.pe));
        chk($sformatf("frame_err_dut%0d", id), 32'(ff), 32'(e.fe));
        chk($sformatf("break_det_dut%0d", id), 32'(bb), 32'(e.bd));
        exp_data[id] = e.data;
        if (!e.pe && !e.fe) exp_led[id] = ~exp_led[id];
      end
    end else begin
      chk($sformatf("idle_flags_dut%0d", id), 32'({pp, ff, bb}), 32'd0);
    end
    chk($sformatf("rx_data_dut%0d", id), 32'(d), 32'(exp_data[id]));
    chk($sformatf("led_dut%0d", id), 32'(ll), 32'(exp_led[id]));
  endtask

  always @(negedge clk) begin
    check_dut(0, {1'b0, d_a}, v[0], pe[0], fe[0], bd[0], led[0]);
    check_dut(1, {1'b0, d_b}, v[1], pe[1], fe[1], bd[1], led[1]);
    check_dut(2, {2'b0, d_c}, v[2], pe[2], fe[2], bd[2], led[2]);
  end

  initial begin
    rst_n = 3'b000;
    line  = 3'b111;
    for (int i = 0; i < 3; i++) begin
      exp_data[i] = '0; exp_led[i] = 1'b0; vcnt[i] = 0;
      last_pe[i] = 1'b0; last_fe[i] = 1'b0; last_bd[i] = 1'b0;
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("reset_data_a", 32'(d_a), 32'd0);
    chk("reset_valid", 32'(v), 32'd0);
    chk("reset_led", 32'(led), 32'd0);
    chk("reset_flags", 32'({pe, fe, bd}), 32'd0);
    chk("model_par_a5_even", 32'(par_bit(9'h0A5, 8, 2)), 32'd0);
    chk("model_par_7f_odd", 32'(par_bit(9'h07F, 7, 1)), 32'd0);
    @(posedge clk);
    rst_n = 3'b111;
    repeat (BIT) @(posedge clk);

    // 8N1 0x55
    send_frame(0, 8, 0, 1, 9'h055, -1, 2'b11);
    repeat (BIT) @(posedge clk);
    @(negedge clk);
    chk("t1_data", 32'(d_a), 32'h55);
    chk("t1_count", 32'(vcnt[0]), 32'd1);
    chk("t1_led", 32'(led[0]), 32'd1);

    // 8E1 0xA5, wrong then correct parity
    send_frame(1, 8, 2, 1, 9'h0A5, 1, 2'b11);
    repeat (BIT) @(posedge clk);
    @(negedge clk);
    chk("t2_bad_count", 32'(vcnt[1]), 32'd1);
    chk("t2_bad_perr", 32'(last_pe[1]), 32'd1);
    chk("t2_bad_data", 32'(d_b), 32'hA5);
    chk("t2_bad_led", 32'(led[1]), 32'd0);
    send_frame(1, 8, 2, 1, 9'h0A5, -1, 2'b11);
    repeat (BIT) @(posedge clk);
    @(negedge clk);
    chk("t2_good_perr", 32'(last_pe[1]), 32'd0);
    chk("t2_good_led", 32'(led[1]), 32'd1);

    // quarter-bit glitch, then 0x3C
    line[0] = 1'b0;
    repeat (BIT / 4) @(posedge clk);
    line[0] = 1'b1;
    repeat (2 * BIT) @(posedge clk);
    @(negedge clk);
    chk("t3_glitch_count", 32'(vcnt[0]), 32'd1);
    send_frame(0, 8, 0, 1, 9'h03C, -1, 2'b11);
    repeat (BIT) @(posedge clk);
    @(negedge clk);
    chk("t3_data", 32'(d_a), 32'h3C);
    chk("t3_count", 32'(vcnt[0]), 32'd2);

    // break: line low for 20 bit times
    push_exp(0, 9'd0, 1'b0, 1'b1, 1'b1);
    line[0] = 1'b0;
    repeat (20 * BIT) @(posedge clk);
    @(negedge clk);
    chk("t4_count", 32'(vcnt[0]), 32'd3);
    chk("t4_frame_err", 32'(last_fe[0]), 32'd1);
    chk("t4_break", 32'(last_bd[0]), 32'd1);
    chk("t4_data", 32'(d_a), 32'd0);
    @(posedge clk);
    line[0] = 1'b1;
    repeat (3 * BIT / 2) @(posedge clk);
    send_frame(0, 8, 0, 1, 9'h012, -1, 2'b11);
    repeat (BIT) @(posedge clk);
    @(negedge clk);
    chk("t4_after_count", 32'(vcnt[0]), 32'd4);
    chk("t4_after_data", 32'(d_a), 32'h12);

    // 7O2 back-to-back, then a low second stop bit
    send_frame(2, 7, 1, 2, 9'h07F, -1, 2'b11);
    send_frame(2, 7, 1, 2, 9'h001, -1, 2'b11);
    @(negedge clk);
    chk("t5_count", 32'(vcnt[2]), 32'd2);
    chk("t5_data", 32'(d_c), 32'h01);
    chk("t5_led", 32'(led[2]), 32'd0);
    @(posedge clk);
    send_frame(2, 7, 1, 2, 9'h02A, -1, 2'b01);
    line[2] = 1'b1;
    repeat (2 * BIT) @(posedge clk);
    @(negedge clk);
    chk("t5_stop2_ferr", 32'(last_fe[2]), 32'd1);
    chk("t5_stop2_count", 32'(vcnt[2]), 32'd3);

    // reset during the data bits of 0xFF, then 0x81
    bit_out(0, 1'b0);
    bit_out(0, 1'b1);
    bit_out(0, 1'b1);
    repeat (BIT / 2) @(posedge clk);
    rst_n[0]    = 1'b0;
    exp_data[0] = '0;
    exp_led[0]  = 1'b0;
    @(negedge clk);
    chk("t6_rst_data", 32'(d_a), 32'd0);
    chk("t6_rst_led", 32'(led[0]), 32'd0);
    chk("t6_rst_valid", 32'(v[0]), 32'd0);
    @(posedge clk);
    rst_n[0] = 1'b1;
    repeat (6 * BIT) @(posedge clk);
    @(negedge clk);
    chk("t6_no_valid", 32'(vcnt[0]), 32'd4);
    @(posedge clk);
    send_frame(0, 8, 0, 1, 9'h081, -1, 2'b11);
    repeat (BIT) @(posedge clk);
    @(negedge clk);
    chk("t6_data", 32'(d_a), 32'h81);
    chk("t6_led", 32'(led[0]), 32'd1);
    chk("t6_count", 32'(vcnt[0]), 32'd5);

    chk("pending_frames", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
